// File: rtl/ssd_digit_sequencer.sv
// Purpose : steps a writable sequence of 4-bit display codes (0-9, F=dash) onto one
//           seven-segment display. Stepping is timed (auto), manual (step) or frozen (hold),
//           with an optional blank gap after the last entry.
// Latency : index/state update on the clock edge after an advance; phone_digit and ssd_out
//           follow combinationally from the registered index and memory.
// Backpressure: none; writes are accepted every cycle and advances are never stalled.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   wr_en/addr/data  sequence memory write port (addresses >= NUM_DIGITS ignored)
//   mode          00 hold, 01 auto, 10 step, 11 hold
//   step_in       debounced manual-step level; each rising edge advances in step mode
//   digit_idx     index currently shown
//   phone_digit   code currently shown (4'hF while blanking)
//   blanking      high during the blank gap
//   wrap_pulse    one-cycle pulse coincident with the index returning to 0
//   ssd_out       segment pattern from the display driver

// Seven-segment encoder: active-low segments ordered {g,f,e,d,c,b,a}.
// Codes 0-9 show digits, 4'hF shows a dash, other codes and enable=0 show all-off.
module ssd_driver (
  input  logic       enable,
  input  logic [3:0] binary_in,
  output logic [6:0] ssd_out
);
  always_comb begin
    ssd_out = 7'h7F;
    if (enable) begin
      case (binary_in)
        4'h0:    ssd_out = 7'h40;
        4'h1:    ssd_out = 7'h79;
        4'h2:    ssd_out = 7'h24;
        4'h3:    ssd_out = 7'h30;
        4'h4:    ssd_out = 7'h19;
        4'h5:    ssd_out = 7'h12;
        4'h6:    ssd_out = 7'h02;
        4'h7:    ssd_out = 7'h78;
        4'h8:    ssd_out = 7'h00;
        4'h9:    ssd_out = 7'h10;
        4'hF:    ssd_out = 7'h3F;
        default: ssd_out = 7'h7F;
      endcase
    end
  end
endmodule

module ssd_digit_sequencer #(
  parameter int NUM_DIGITS  = 8,
  parameter int IDX_W       = 3,
  parameter int TICK_DIV    = 50000000,
  parameter int BLANK_TICKS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [3:0]       wr_data,
  input  logic [1:0]       mode,
  input  logic             step_in,
  output logic [IDX_W-1:0] digit_idx,
  output logic [3:0]       phone_digit,
  output logic             blanking,
  output logic             wrap_pulse,
  output logic [6:0]       ssd_out
);
  // Memory spans the full index space so any index value is a legal array
  // subscript; entries at or above NUM_DIGITS are never written or shown.
  localparam int MEM_D  = 1 << IDX_W;
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int BLK_W  = (BLANK_TICKS < 1) ? 1 : $clog2(BLANK_TICKS + 1);

  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W:0]    NUM_D    = (IDX_W + 1)'(NUM_DIGITS);
  // Blank counter value whose increment would reach BLANK_TICKS.
  localparam logic [BLK_W-1:0]  BLK_LAST = BLK_W'((BLANK_TICKS == 0) ? 0 : BLANK_TICKS - 1);

  typedef enum logic {S_SHOW = 1'b0, S_BLANK = 1'b1} state_t;

  state_t            state;
  logic [3:0]        mem [MEM_D];
  logic [TICK_W-1:0] tick_cnt;
  logic [BLK_W-1:0]  blank_cnt;
  logic              step_q;
  logic              is_auto;
  logic              is_step;
  logic              adv;

  assign is_auto = (mode == 2'b01);
  assign is_step = (mode == 2'b10);

  // step_q tracks step_in in every mode, so entering step mode with the
  // button already held does not count as an edge.
  assign adv = (is_auto && (tick_cnt == TICK_MAX)) ||
               (is_step && step_in && !step_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_D; i++) begin
        mem[i] <= 4'hF;
      end
      digit_idx  <= '0;
      tick_cnt   <= '0;
      blank_cnt  <= '0;
      state      <= S_SHOW;
      blanking   <= 1'b0;
      wrap_pulse <= 1'b0;
      step_q     <= 1'b0;
    end else begin
      step_q     <= step_in;
      wrap_pulse <= 1'b0;

      if (wr_en && ({1'b0, wr_addr} < NUM_D)) begin
        mem[wr_addr] <= wr_data;
      end

      // The counter only runs in auto mode; being held at 0 everywhere else
      // means any mode change restarts the interval from a cleared counter.
      if (!is_auto || (tick_cnt == TICK_MAX)) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + TICK_W'(1);
      end

      if (adv) begin
        case (state)
          S_SHOW: begin
            if (digit_idx != LAST_IDX) begin
              digit_idx <= digit_idx + IDX_W'(1);
            end else if (BLANK_TICKS == 0) begin
              digit_idx  <= '0;
              wrap_pulse <= 1'b1;
            end else begin
              state     <= S_BLANK;
              blanking  <= 1'b1;
              blank_cnt <= '0;
            end
          end
          S_BLANK: begin
            if (blank_cnt == BLK_LAST) begin
              state      <= S_SHOW;
              blanking   <= 1'b0;
              digit_idx  <= '0;
              wrap_pulse <= 1'b1;
            end else begin
              blank_cnt <= blank_cnt + BLK_W'(1);
            end
          end
          default: begin
            state    <= S_SHOW;
            blanking <= 1'b0;
          end
        endcase
      end
    end
  end

  assign phone_digit = blanking ? 4'hF : mem[digit_idx];

  ssd_driver u_ssd_driver (
    .enable    (~blanking),
    .binary_in (phone_digit),
    .ssd_out   (ssd_out)
  );
endmodule
